hard_mem_1rw_byte_mask_req_adapter: RTL
=======================================

Name: hard_mem_1rw_byte_mask_req_adapter

Overview:
Requester-side controller for the single-port byte-masked SRAM wrappers: the master that drives the memory's v/w/addr/data/write_mask pins and consumes its data_o. It converts a valid/ready request stream into SRAM accesses. The SRAM's read data is valid only in the cycle after a read and goes X afterwards, so the block captures it in that cycle into a response buffer with valid/yumi handshake and credit-based flow control. It sits between a cache/TLB pipeline and a hard_mem_1rw_byte_mask_* wrapper.

Parameters:
width_p, 64, data width; must be a multiple of 8
els_p, 512, memory depth
addr_width_lp, $clog2(els_p), address width (localparam)
write_mask_width_lp, width_p>>3, byte-mask width (localparam)
buf_els_p, 3, response buffer entries; minimum 2; 3 gives one read per cycle at full throughput

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
v_i  in  1  request valid
w_i  in  1  1 = write, 0 = read
addr_i  in  addr_width_lp  request address
data_i  in  width_p  write data
write_mask_i  in  write_mask_width_lp  byte enables for writes
ready_o  out  1  request accepted when v_i & ready_o
data_o  out  width_p  read response data
v_o  out  1  response valid
yumi_i  in  1  response consumed; asserted only when v_o is high
init_done_o  out  1  memory initialisation complete
mem_v_o  out  1  to SRAM v_i
mem_w_o  out  1  to SRAM w_i
mem_addr_o  out  addr_width_lp  to SRAM addr_i
mem_data_o  out  width_p  to SRAM data_i
mem_write_mask_o  out  write_mask_width_lp  to SRAM write_mask_i
mem_data_i  in  width_p  from SRAM data_o

Behaviour:
- Reset: ready_o=0, v_o=0, mem_v_o=0, pending_r=0, buffer empty, occupancy=0. data_o is don't-care while v_o=0.
- ready_o is registered-state only: it does not combinationally depend on v_i, w_i or yumi_i.
- ready_o = state READY & (pending_r + occupancy < buf_els_p). Writes use the same rule, so ordering stays simple.
- On accept: mem_v_o=1 in the same cycle. mem_w_o, mem_addr_o, mem_data_o and mem_write_mask_o pass through combinationally. There is no SRAM access when nothing is accepted.
- A read accept sets pending_r at the clock edge.
- In the next cycle, mem_data_i is written into the buffer tail. That entry shows v_o=1 one cycle later, giving 2 cycles of read latency from accept to v_o.
- Writes produce no response.
- Response buffer: FIFO of buf_els_p entries with wrapping head/tail pointers. v_o = occupancy!=0 and data_o = head entry. yumi_i pops the head.
- A capture and a pop in the same cycle leave occupancy unchanged. This is legal even when the buffer is full.
- The credit rule guarantees there is never a capture into a full buffer. An assertion fires if one occurs, and also if yumi_i is high while v_o is low.
- Back-to-back reads: one per cycle is sustained when buf_els_p>=3 and yumi_i is held high.
- States: INIT, READY (2-bit encoding; RESET is implied by reset_i).
  - Reset forces INIT when the macro is enabled, otherwise READY.
- Reset mid-operation: any in-flight read is dropped, the buffer is flushed, and mem_v_o is low during the reset cycle.

Optional Feature:
HARD_MEM_1RW_REQ_ADAPTER_INIT_EN
- Defined: after reset deasserts, the state is INIT. One write per cycle goes to addresses 0..els_p-1 with mem_data_o=0 and all mask bits set.
  - ready_o=0 and init_done_o=0 throughout the sweep.
  - In the cycle after the write to els_p-1, the state moves to READY and init_done_o=1. ready_o therefore rises on cycle els_p after the reset release.
  - Reset during INIT restarts the sweep at address 0.
- Undefined: no sweep counter is built. The block enters READY directly, with init_done_o=1 and ready_o=1 in the first cycle after reset.

Test Plan:
- Write 0xDEADBEEF_CAFEF00D to addr 5 with mask 0xFF, then read addr 5 -> v_o at read-accept+2, data_o=0xDEADBEEF_CAFEF00D.
- Write mask 0x0F with data 0x11111111_22222222 over the prior value at addr 5, then read -> data_o=0xDEADBEEF_22222222.
- 8 consecutive reads of addrs 0..7 with yumi_i=1 every cycle (buf_els_p=3) -> ready_o never drops, and 8 responses arrive in order on consecutive cycles.
- Reads with yumi_i=0 -> ready_o drops after 3 accepts and v_o stays high holding the first response. One yumi -> exactly one new accept is allowed.
- Assert reset_i the cycle after a read accept -> no response appears, and v_o=0 and occupancy=0 after reset.
- Macro defined, els_p=512: release reset, then read addr 511 once ready -> ready_o first high on cycle 512, data_o=0. Reset at cycle 100 -> sweep restarts at 0.

Source files
------------

// File: rtl/hard_mem_1rw_byte_mask_req_adapter.sv
// Requester-side controller for a single-port byte-masked SRAM: accepts valid/ready requests,
// captures read data in the cycle after the access, and returns it through a credit-limited FIFO.
// Optional power-up zeroing sweep is enabled by defining HARD_MEM_1RW_REQ_ADAPTER_INIT_EN.
module hard_mem_1rw_byte_mask_req_adapter #(
    parameter int width_p   = 64,
    parameter int els_p     = 512,
    parameter int buf_els_p = 3,
    localparam int addr_width_lp       = $clog2(els_p),
    localparam int write_mask_width_lp = width_p >> 3
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           v_i,
    input  logic                           w_i,
    input  logic [addr_width_lp-1:0]       addr_i,
    input  logic [width_p-1:0]             data_i,
    input  logic [write_mask_width_lp-1:0] write_mask_i,
    output logic                           ready_o,
    output logic [width_p-1:0]             data_o,
    output logic                           v_o,
    input  logic                           yumi_i,
    output logic                           init_done_o,
    output logic                           mem_v_o,
    output logic                           mem_w_o,
    output logic [addr_width_lp-1:0]       mem_addr_o,
    output logic [width_p-1:0]             mem_data_o,
    output logic [write_mask_width_lp-1:0] mem_write_mask_o,
    input  logic [width_p-1:0]             mem_data_i
);

    localparam int ptr_w_lp = $clog2(buf_els_p);
    localparam int cnt_w_lp = $clog2(buf_els_p + 1);

    // Handshake: a request transfers on a cycle where v_i & ready_o; a response transfers on a
    // cycle where v_o & yumi_i. ready_o depends only on registered state (and reset_i).
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_READY = 2'd1
    } state_e;

    state_e                state_q, state_d;
    logic                  pending_q, pending_d;
    logic [ptr_w_lp-1:0]   head_q, head_d;
    logic [ptr_w_lp-1:0]   tail_q, tail_d;
    logic [cnt_w_lp-1:0]   count_q, count_d;
    logic [width_p-1:0]    buf_mem_q [buf_els_p];

    logic                  accept;
    logic                  capture;
    logic                  pop;
    logic [cnt_w_lp:0]     credits_used;

`ifdef HARD_MEM_1RW_REQ_ADAPTER_INIT_EN
    logic [addr_width_lp-1:0] init_addr_q, init_addr_d;
`endif

    always_comb begin
        // Reads in flight plus buffered responses must stay below the buffer size.
        credits_used = {1'b0, count_q} + {{cnt_w_lp{1'b0}}, pending_q};
        ready_o      = !reset_i && (state_q == ST_READY)
                       && (credits_used < (cnt_w_lp + 1)'(buf_els_p));
        accept       = v_i && ready_o;
        capture      = pending_q;
        pop          = yumi_i && (count_q != '0);

        v_o          = (count_q != '0);
        data_o       = buf_mem_q[head_q];
        init_done_o  = (state_q == ST_READY);

        mem_v_o          = accept;
        mem_w_o          = w_i;
        mem_addr_o       = addr_i;
        mem_data_o       = data_i;
        mem_write_mask_o = write_mask_i;

        state_d   = state_q;
        pending_d = accept && !w_i;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q + cnt_w_lp'(capture) - cnt_w_lp'(pop);

        if (capture) begin
            tail_d = (tail_q == ptr_w_lp'(buf_els_p - 1)) ? '0 : tail_q + ptr_w_lp'(1);
        end
        if (pop) begin
            head_d = (head_q == ptr_w_lp'(buf_els_p - 1)) ? '0 : head_q + ptr_w_lp'(1);
        end

`ifdef HARD_MEM_1RW_REQ_ADAPTER_INIT_EN
        init_addr_d = init_addr_q;
        if (state_q == ST_INIT && !reset_i) begin
            mem_v_o          = 1'b1;
            mem_w_o          = 1'b1;
            mem_addr_o       = init_addr_q;
            mem_data_o       = '0;
            mem_write_mask_o = '1;
            init_addr_d      = init_addr_q + addr_width_lp'(1);
            if (init_addr_q == addr_width_lp'(els_p - 1)) begin
                state_d = ST_READY;
            end
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
`ifdef HARD_MEM_1RW_REQ_ADAPTER_INIT_EN
            state_q     <= ST_INIT;
            init_addr_q <= '0;
`else
            state_q     <= ST_READY;
`endif
            pending_q   <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
`ifdef HARD_MEM_1RW_REQ_ADAPTER_INIT_EN
            init_addr_q <= init_addr_d;
`endif
            state_q     <= state_d;
            pending_q   <= pending_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    // SRAM read data is only valid for one cycle, so it is latched unconditionally when pending.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            buf_mem_q[tail_q] <= mem_data_i;
        end
    end

    no_yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        !(yumi_i && !v_o));

    no_capture_into_full: assert property (@(posedge clk_i) disable iff (reset_i)
        !(pending_q && (count_q == cnt_w_lp'(buf_els_p)) && !yumi_i));

endmodule
